// File: rtl/frame_arb_pkg.sv
// Shared definitions for the frame read arbiters.
//   NUM_SW_INST_DEF : default number of switch instances / output FIFOs
//   FIFO_SW_0..4    : one-hot rd_sel codes, identical to the frame mux decode
//   arb_state_e     : arbiter FSM encoding
package frame_arb_pkg;

  localparam int NUM_SW_INST_DEF = 5;

  localparam logic [NUM_SW_INST_DEF-1:0] FIFO_SW_0 = 5'b00001;
  localparam logic [NUM_SW_INST_DEF-1:0] FIFO_SW_1 = 5'b00010;
  localparam logic [NUM_SW_INST_DEF-1:0] FIFO_SW_2 = 5'b00100;
  localparam logic [NUM_SW_INST_DEF-1:0] FIFO_SW_3 = 5'b01000;
  localparam logic [NUM_SW_INST_DEF-1:0] FIFO_SW_4 = 5'b10000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    GRANT = 2'd2
  } arb_state_e;

endpackage

// File: rtl/frame_rd_arbiter_if.sv
// Bus between the output FIFOs / downstream sink and the frame read arbiter.
//   en          : arbitration enable
//   fifo_empty  : per-FIFO empty flag (FWFT FIFOs)
//   out_ready   : downstream can capture frame_out next cycle
//   rd_sel      : one-hot pop / mux steer (all zero = no pop)
//   frame_valid : registered frame_out valid
//   frame_src   : registered source index of frame_out
//   busy        : arbiter is in GRANT
// Modports: slave = arbiter side, master = FIFO/sink side.
interface frame_rd_arbiter_if #(
  parameter int NUM_SW_INST = 5,
  parameter int SRC_W       = (NUM_SW_INST > 1) ? $clog2(NUM_SW_INST) : 1
);
  logic                   en;
  logic [NUM_SW_INST-1:0] fifo_empty;
  logic                   out_ready;
  logic [NUM_SW_INST-1:0] rd_sel;
  logic                   frame_valid;
  logic [SRC_W-1:0]       frame_src;
  logic                   busy;

  modport slave (
    input  en, fifo_empty, out_ready,
    output rd_sel, frame_valid, frame_src, busy
  );

  modport master (
    output en, fifo_empty, out_ready,
    input  rd_sel, frame_valid, frame_src, busy
  );
endinterface

// File: rtl/frame_rd_arbiter_rr_pick.sv
// Round-robin pick: lowest index i >= ptr with req[i] set, wrapping modulo
// NUM_SW_INST. Purely combinational.
//   req : request vector
//   ptr : starting index (highest priority)
//   idx : chosen index (0 when any is low)
//   any : at least one request present
module rr_pick
  import frame_arb_pkg::*;
#(
  parameter int NUM_SW_INST = NUM_SW_INST_DEF,
  parameter int SRC_W       = (NUM_SW_INST > 1) ? $clog2(NUM_SW_INST) : 1
) (
  input  logic [NUM_SW_INST-1:0] req,
  input  logic [SRC_W-1:0]       ptr,
  output logic [SRC_W-1:0]       idx,
  output logic                   any
);

  logic [SRC_W-1:0] j;

  // Walk offsets from farthest to nearest so the last hit written is the
  // one closest to ptr; avoids a loop break.
  always_comb begin
    idx = '0;
    any = 1'b0;
    j   = '0;
    for (int k = NUM_SW_INST - 1; k >= 0; k--) begin
      j = SRC_W'((int'(ptr) + k) % NUM_SW_INST);
      if (req[j]) begin
        idx = j;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_rd_arbiter.sv
// Round-robin read scheduler for the per-switch-instance output FIFOs that
// feed the registered frame mux. rd_sel pops one FIFO and steers the mux in
// the same cycle; frame_valid/frame_src are registered so they line up with
// the mux output one cycle later. Each grant covers up to BURST_LEN frames,
// stalls on out_ready, and ends early when the granted FIFO empties.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : frame_rd_arbiter_if slave (en, fifo_empty, out_ready in;
//                rd_sel, frame_valid, frame_src, busy out)
module frame_rd_arbiter
  import frame_arb_pkg::*;
#(
  parameter int NUM_SW_INST = NUM_SW_INST_DEF,
  parameter int BURST_LEN   = 4,
  parameter int SRC_W       = (NUM_SW_INST > 1) ? $clog2(NUM_SW_INST) : 1
) (
  input logic               clk,
  input logic               rst_n,
  frame_rd_arbiter_if.slave bus
);

  localparam logic [7:0]             BL_LAST = 8'(BURST_LEN - 1);
  localparam logic [NUM_SW_INST-1:0] ONE     = NUM_SW_INST'(1);

  arb_state_e       state, state_nxt;
  logic [SRC_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [SRC_W-1:0] winner, winner_nxt;
  logic [7:0]       burst_cnt, burst_nxt;

  logic [NUM_SW_INST-1:0] req;
  logic [SRC_W-1:0]       pick_idx;
  logic                   pick_any;
  logic [SRC_W-1:0]       ptr_after;
  logic                   pop;

  assign req = ~bus.fifo_empty;

  rr_pick #(
    .NUM_SW_INST (NUM_SW_INST),
    .SRC_W       (SRC_W)
  ) u_pick (
    .req (req),
    .ptr (rr_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Next round starts just past the source that held the grant.
  assign ptr_after = (winner == SRC_W'(NUM_SW_INST - 1)) ? '0 : winner + 1'b1;

  // Mealy pop: the live empty flag gates it, so an emptied FIFO is never read.
  assign pop = (state == GRANT) && bus.en && bus.out_ready && !bus.fifo_empty[winner];

  assign bus.rd_sel = pop ? (ONE << winner) : '0;
  assign bus.busy   = (state == GRANT);

  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    winner_nxt = winner;
    burst_nxt  = burst_cnt;
    case (state)
      IDLE: begin
        if (bus.en && |req) state_nxt = ARB;
      end
      ARB: begin
        if (!bus.en || !pick_any) begin
          state_nxt = IDLE;
        end else begin
          winner_nxt = pick_idx;
          burst_nxt  = '0;
          state_nxt  = GRANT;
        end
      end
      GRANT: begin
        if (!bus.en) begin
          state_nxt = IDLE;
          burst_nxt = '0;
        end else if (pop) begin
          if (burst_cnt == BL_LAST) begin
            rr_ptr_nxt = ptr_after;
            state_nxt  = ARB;
          end else begin
            burst_nxt = burst_cnt + 8'd1;
          end
        end else if (bus.fifo_empty[winner]) begin
          // Source ran dry: give up the rest of the burst.
          rr_ptr_nxt = ptr_after;
          state_nxt  = ARB;
        end
        // Otherwise out_ready stall: hold grant and count.
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      winner    <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      winner    <= winner_nxt;
      burst_cnt <= burst_nxt;
    end
  end

  // Registered alongside the mux, which captures the popped word on this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.frame_valid <= 1'b0;
      bus.frame_src   <= '0;
    end else begin
      bus.frame_valid <= pop;
      bus.frame_src   <= winner;
    end
  end

endmodule

// File: tb/tb_frame_rd_arbiter.sv
module tb_frame_rd_arbiter;
  import frame_arb_pkg::*;

  logic clk;
  logic rst_n;

  frame_rd_arbiter_if #(.NUM_SW_INST(5)) bus4 ();
  frame_rd_arbiter_if #(.NUM_SW_INST(5)) bus1 ();

  frame_rd_arbiter #(.NUM_SW_INST(5), .BURST_LEN(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  frame_rd_arbiter #(.NUM_SW_INST(5), .BURST_LEN(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int c4[5];
  int c1[5];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic upd();
    for (int i = 0; i < 5; i++) begin
      bus4.fifo_empty[i] = (c4[i] == 0);
      bus1.fifo_empty[i] = (c1[i] == 0);
    end
  endtask

  // One clock: sanity-check the live rd_sel, step the edge, then pop the
  // FIFO model for whatever was selected.
  task automatic cyc();
    logic [4:0] s4, s1;
    s4 = bus4.rd_sel;
    s1 = bus1.rd_sel;
    chk("onehot4",    32'($onehot0(s4)), 1);
    chk("onehot1",    32'($onehot0(s1)), 1);
    chk("pop_empty4", 32'(s4 & bus4.fifo_empty), 0);
    chk("pop_empty1", 32'(s1 & bus1.fifo_empty), 0);
    chk("pop_nogr4",  32'((s4 != 0) && !bus4.busy), 0);
    chk("pop_nogr1",  32'((s1 != 0) && !bus1.busy), 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      if (s4[i]) c4[i]--;
      if (s1[i]) c1[i]--;
    end
    upd();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus4.en = 1'b0; bus4.out_ready = 1'b1;
    bus1.en = 1'b0; bus1.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin c4[i] = 0; c1[i] = 0; end
    upd();
    #1;
    repeat (2) cyc();
    rst_n = 1'b1;
    #1;
  endtask

  logic [15:0] e_pop, e_fv, e_busy;
  logic [4:0]  e_rd;
  int          n_fv;

  initial begin
    // ---- reset / idle
    rst_n = 1'b0;
    bus4.en = 1'b0; bus4.out_ready = 1'b1;
    bus1.en = 1'b0; bus1.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin c4[i] = 0; c1[i] = 0; end
    upd();
    #1;
    chk("rst_rd",   32'(bus4.rd_sel), 0);
    chk("rst_fv",   32'(bus4.frame_valid), 0);
    chk("rst_src",  32'(bus4.frame_src), 0);
    chk("rst_busy", 32'(bus4.busy), 0);
    chk("rst_fv1",  32'(bus1.frame_valid), 0);
    repeat (2) cyc();
    rst_n = 1'b1;
    bus4.en = 1'b1;
    #1;
    for (int c = 0; c < 20; c++) begin
      chk($sformatf("idle_rd%0d", c),   32'(bus4.rd_sel), 0);
      chk($sformatf("idle_fv%0d", c),   32'(bus4.frame_valid), 0);
      chk($sformatf("idle_busy%0d", c), 32'(bus4.busy), 0);
      cyc();
    end

    // ---- single source FIFO2, 6 frames, burst 4 then wrap-back burst of 2
    do_reset();
    c4[2] = 6; bus4.en = 1'b1; upd(); #1;
    e_pop  = 16'b0000_0001_1011_1100;
    e_fv   = 16'b0000_0011_0111_1000;
    e_busy = 16'b0000_0011_1011_1100;
    n_fv = 0;
    for (int c = 0; c < 12; c++) begin
      e_rd = e_pop[c] ? FIFO_SW_2 : 5'b0;
      chk($sformatf("ss_rd%0d", c),   32'(bus4.rd_sel), 32'(e_rd));
      chk($sformatf("ss_fv%0d", c),   32'(bus4.frame_valid), 32'(e_fv[c]));
      chk($sformatf("ss_busy%0d", c), 32'(bus4.busy), 32'(e_busy[c]));
      if (bus4.frame_valid) begin
        n_fv++;
        chk($sformatf("ss_src%0d", c), 32'(bus4.frame_src), 2);
      end
      cyc();
    end
    chk("ss_fv_count", 32'(n_fv), 6);
    chk("ss_left", 32'(c4[2]), 0);

    // ---- round-robin fairness, burst 1, all full
    do_reset();
    for (int i = 0; i < 5; i++) c1[i] = 10;
    bus1.en = 1'b1; upd(); #1;
    for (int c = 0; c < 14; c++) begin
      e_rd = (c >= 2 && c % 2 == 0) ? (5'b00001 << (((c - 2) / 2) % 5)) : 5'b0;
      chk($sformatf("rr_rd%0d", c), 32'(bus1.rd_sel), 32'(e_rd));
      chk($sformatf("rr_fv%0d", c), 32'(bus1.frame_valid), 32'(c >= 3 && c % 2 == 1));
      if (c >= 3 && c % 2 == 1)
        chk($sformatf("rr_src%0d", c), 32'(bus1.frame_src), 32'(((c - 3) / 2) % 5));
      cyc();
    end

    // ---- backpressure mid-burst on FIFO1
    do_reset();
    c4[1] = 10; bus4.en = 1'b1; upd(); #1;
    e_pop  = 16'b0000_0101_1000_1100;
    e_fv   = 16'b0000_0011_0001_1000;
    e_busy = 16'b0000_0101_1111_1100;
    for (int c = 0; c < 11; c++) begin
      bus4.out_ready = !(c >= 4 && c <= 6);
      #1;
      e_rd = e_pop[c] ? FIFO_SW_1 : 5'b0;
      chk($sformatf("bp_rd%0d", c),   32'(bus4.rd_sel), 32'(e_rd));
      chk($sformatf("bp_fv%0d", c),   32'(bus4.frame_valid), 32'(e_fv[c]));
      chk($sformatf("bp_busy%0d", c), 32'(bus4.busy), 32'(e_busy[c]));
      cyc();
    end

    // ---- early empty: FIFO3 has 2, FIFO4 full
    do_reset();
    c4[3] = 2; c4[4] = 20; bus4.en = 1'b1; upd(); #1;
    e_fv = 16'b0000_0000_1001_1000;
    for (int c = 0; c < 8; c++) begin
      e_rd = (c == 2 || c == 3) ? FIFO_SW_3 : (c == 6 || c == 7) ? FIFO_SW_4 : 5'b0;
      chk($sformatf("ee_rd%0d", c), 32'(bus4.rd_sel), 32'(e_rd));
      chk($sformatf("ee_fv%0d", c), 32'(bus4.frame_valid), 32'(e_fv[c]));
      if (e_fv[c])
        chk($sformatf("ee_src%0d", c), 32'(bus4.frame_src), (c <= 4) ? 3 : 4);
      cyc();
    end
    chk("ee_left3", 32'(c4[3]), 0);

    // ---- async reset mid-GRANT with rr_ptr moved off zero
    do_reset();
    c4[0] = 10; c4[2] = 10; bus4.en = 1'b1; upd(); #1;
    for (int c = 0; c < 8; c++) begin
      e_rd = (c >= 2 && c <= 5) ? FIFO_SW_0 : (c == 7) ? FIFO_SW_2 : 5'b0;
      chk($sformatf("ar_rd%0d", c), 32'(bus4.rd_sel), 32'(e_rd));
      if (c < 7) cyc();
    end
    rst_n = 1'b0;
    #1;
    chk("ar_rst_rd",   32'(bus4.rd_sel), 0);
    chk("ar_rst_fv",   32'(bus4.frame_valid), 0);
    chk("ar_rst_src",  32'(bus4.frame_src), 0);
    chk("ar_rst_busy", 32'(bus4.busy), 0);
    cyc();
    chk("ar_nopop2", 32'(c4[2]), 10);
    rst_n = 1'b1;
    #1;
    chk("ar_rel_busy", 32'(bus4.busy), 0);
    chk("ar_rel_fv",   32'(bus4.frame_valid), 0);
    cyc();
    chk("ar_arb_busy", 32'(bus4.busy), 0);
    chk("ar_arb_rd",   32'(bus4.rd_sel), 0);
    cyc();
    chk("ar_ptr0_rd",  32'(bus4.rd_sel), 32'(FIFO_SW_0));

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/frame_rd_arbiter.md
Name: frame_rd_arbiter

Overview:
- Round-robin read scheduler for the per-switch-instance output FIFOs feeding the registered frame mux.
- Produces the one-hot rd_sel that pops one FIFO and steers the mux in the same cycle.
- Flags the resulting frame_out cycle with frame_valid and the source index.
- Grants up to BURST_LEN consecutive frames per source, respects downstream out_ready, and skips empty FIFOs.

Parameters:
- NUM_SW_INST, 5: number of switch instances / FIFOs; rd_sel width.
- BURST_LEN, 4: max frames popped from one source per grant (1..255).
- SRC_W, $clog2(NUM_SW_INST): width of the source index.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: reset; asynchronous, active-low.
- en, input, 1: arbitration enable.
- fifo_empty, input, NUM_SW_INST: per-FIFO empty flag; bit i = FIFO i. FIFOs are first-word-fall-through.
- out_ready, input, 1: downstream can capture frame_out on the next cycle.
- rd_sel, output, NUM_SW_INST: one-hot pop/steer; all zero = no pop.
- frame_valid, output, 1: frame_out from the mux is valid this cycle.
- frame_src, output, SRC_W: source index of the current frame_out.
- busy, output, 1: high when state = GRANT.

Behaviour:
- Reset values: state IDLE, rr_ptr 0, winner 0, burst_cnt 0, frame_valid 0, frame_src 0. rd_sel is 0 in reset because it is gated by state.
- Pick (rr_ptr, req = ~fifo_empty): lowest index i ≥ rr_ptr with req[i] set, wrapping modulo NUM_SW_INST.
- States:
  - IDLE: if en && |req, go to ARB; otherwise stay.
  - ARB (1 cycle, no pop): winner <= pick(rr_ptr, req), burst_cnt <= 0, go to GRANT. If req is all zero or en is low here, return to IDLE.
- pop = (state == GRANT) && en && out_ready && ~fifo_empty[winner].
- rd_sel = pop ? onehot(winner) : 0. This is a Mealy output, combinational from registered state and the current inputs, so a FIFO that empties is never popped.
- GRANT transitions, evaluated at the clock edge:
  - pop with burst_cnt == BURST_LEN-1: rr_ptr <= winner+1 (wrap to 0 after NUM_SW_INST-1), go to ARB.
  - pop with burst_cnt < BURST_LEN-1: burst_cnt++, stay in GRANT.
  - no pop because fifo_empty[winner] is high: rr_ptr <= winner+1, go to ARB. The burst ends early.
  - no pop because out_ready is low: stay in GRANT, burst_cnt held. Stalling does not lose the grant.
  - en low: go to IDLE, rr_ptr unchanged, burst_cnt cleared.
- Output timing: frame_valid <= pop and frame_src <= winner, both registered. This aligns with the mux, which registers frame_in_x on the same edge that rd_sel is sampled.
  - Latency: pop in cycle N gives frame_valid and frame_out in cycle N+1.
  - When frame_valid is 0, frame_out is 0 (mux default) and must be ignored.
- Arbitration overhead: one ARB bubble between sources. Maximum throughput is BURST_LEN frames per BURST_LEN+1 cycles.
- rd_sel is never multi-hot and is never asserted outside GRANT.
- Reset mid-burst: all registers return to reset values immediately. No pop occurs after rst_n falls.

Decomposition:
- Shared package (frame_arb_pkg):
  - NUM_SW_INST default.
  - FIFO_SW_0..FIFO_SW_4 one-hot constants, matching the mux decode.
  - State encoding IDLE=2'd0, ARB=2'd1, GRANT=2'd2.
- Sub-module rr_pick: purely combinational, inputs req[NUM_SW_INST] and ptr[SRC_W], outputs idx[SRC_W] and any. Reused by later arbiters.

Test Plan:
- Reset/idle: rst_n=0, then 1, fifo_empty=5'b11111, en=1 → rd_sel stays 0, frame_valid 0, state IDLE for 20 cycles.
- Single source, BURST_LEN=4: FIFO2 holds 6 frames, others empty → ARB, then 4 pops with rd_sel=5'b00100, then ARB (rr_ptr=3). Pick wraps to 2 and pops 2 more. FIFO2 then empties → ARB → IDLE. frame_valid is asserted exactly 6 times, each one cycle after its rd_sel, with frame_src=2.
- Round-robin fairness: all 5 FIFOs full, BURST_LEN=1, out_ready=1 → frame_src sequence 0,1,2,3,4,0,… with an ARB bubble between each pop.
- Backpressure: out_ready=0 for 3 cycles mid-burst on FIFO1 → rd_sel=0 and frame_valid=0 during the stall. burst_cnt is held, and the remaining burst completes on FIFO1 when out_ready returns.
- Early empty: FIFO3 has 2 frames, BURST_LEN=4, FIFO4 full → 2 pops from FIFO3. The no-pop cycle on empty moves to ARB, and the next grant is FIFO4. FIFO3 is never read while empty.
- Async reset mid-GRANT: rst_n=0 asynchronously during a pop cycle → rd_sel, frame_valid and frame_src are 0 before the next edge. After release: IDLE, rr_ptr=0.
